// File: rtl/xcvr_link_pkg.sv
// Shared types for the 10GBASE-R link recovery supervisor.
// The state encoding doubles as the link_state status register map.
package xcvr_link_pkg;

    localparam int RETRY_W = 4;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RST_ASSERT = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_LINK_UP    = 3'd3,
        ST_FAULT      = 3'd4
    } link_state_e;

    localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

endpackage

// File: rtl/xcvr_bit_sync.sv
// Two-flop synchroniser, asynchronously cleared to 0.
module xcvr_bit_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/xcvr_link_recovery.sv
// Link supervisor: sequences transceiver resets, qualifies block lock and
// declares link up; retries on timeout or lock loss, parks in FAULT after budget.
module xcvr_link_recovery
    import xcvr_link_pkg::*;
#(
    parameter int RESET_PULSE_CYCLES   = 16,
    parameter int READY_TIMEOUT_CYCLES = 1000000,
    parameter int LOCK_TIMEOUT_CYCLES  = 1000000,
    parameter int LOCK_STABLE_CYCLES   = 64,
    parameter int LOSS_FILTER_CYCLES   = 8,
    parameter int MAX_RETRIES          = 7,
    parameter int CNT_W                = 24
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               force_reset,
    input  logic               tx_ready,
    input  logic               rx_ready,
    input  logic               rx_block_lock,
    output logic               xcvr_reset,
    output logic               mac_reset_n,
    output logic               link_up,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic [STATE_W-1:0] link_state
);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_N   = CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [CNT_W-1:0] LOSS_N     = CNT_W'(LOSS_FILTER_CYCLES);

    logic rst_n_s;
    logic lock_s;

    // Reset assertion is immediate; release is aligned to clock.
    xcvr_bit_sync u_rst_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .d_i    (1'b1),
        .q_o    (rst_n_s)
    );

    xcvr_bit_sync u_lock_sync (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .d_i    (rx_block_lock),
        .q_o    (lock_s)
    );

    link_state_e        state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   stable_q, stable_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
    logic               xcvr_reset_q, link_up_q, fault_q;
    logic               ready, fail, budget_spent;

    assign ready        = tx_ready & rx_ready;
    assign retry_inc    = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;
    assign budget_spent = (MAX_RETRIES != 0) && (int'(retry_inc) >= MAX_RETRIES);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q + 1'b1;
        stable_d = '0;
        loss_d   = '0;
        retry_d  = retry_q;
        fail     = 1'b0;
        unique case (state_q)
            ST_RST_ASSERT: begin
                if (timer_q == PULSE_LAST) begin
                    state_d = ST_WAIT_READY;
                    timer_d = '0;
                end
            end
            ST_WAIT_READY: begin
                if (ready) begin
                    state_d = ST_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == READY_LAST) begin
                    fail = 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Stable completion is checked ahead of the timeout so it wins a tie.
                if (!ready) begin
                    fail = 1'b1;
                end else if (stable_q == STABLE_N) begin
                    state_d = ST_LINK_UP;
                    timer_d = '0;
                    retry_d = '0;
                end else if (timer_q == LOCK_LAST) begin
                    fail = 1'b1;
                end else begin
                    stable_d = lock_s ? stable_q + 1'b1 : '0;
                end
            end
            ST_LINK_UP: begin
                timer_d = '0;
                if (!ready || loss_q == LOSS_N) begin
                    fail = 1'b1;
                end else begin
                    loss_d = lock_s ? '0 : loss_q + 1'b1;
                end
            end
            ST_FAULT: begin
                timer_d = '0;
            end
            default: begin
                state_d = ST_RST_ASSERT;
                timer_d = '0;
            end
        endcase

        if (fail) begin
            retry_d = retry_inc;
            timer_d = '0;
            state_d = budget_spent ? ST_FAULT : ST_RST_ASSERT;
        end

        if (force_reset) begin
            state_d  = ST_RST_ASSERT;
            timer_d  = '0;
            stable_d = '0;
            loss_d   = '0;
            retry_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q      <= ST_RST_ASSERT;
            timer_q      <= '0;
            stable_q     <= '0;
            loss_q       <= '0;
            retry_q      <= '0;
            xcvr_reset_q <= 1'b1;
            link_up_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            stable_q     <= stable_d;
            loss_q       <= loss_d;
            retry_q      <= retry_d;
            xcvr_reset_q <= (state_d == ST_RST_ASSERT) || (state_d == ST_FAULT);
            link_up_q    <= (state_d == ST_LINK_UP);
            fault_q      <= (state_d == ST_FAULT);
        end
    end

    assign xcvr_reset  = xcvr_reset_q;
    assign mac_reset_n = link_up_q;
    assign link_up     = link_up_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign link_state  = state_q;

endmodule

// File: tb/tb_xcvr_link_recovery.sv
// Scenario bench for xcvr_link_recovery plus a randomized run against a
// cycle-level behavioural model of the link bring-up rules.
module tb_xcvr_link_recovery;

    localparam int PULSE = 4;
    localparam int RT    = 32;
    localparam int LT    = 32;
    localparam int STB   = 8;
    localparam int LOSS  = 4;
    localparam int MAXR  = 3;
    localparam int SYNC  = 2;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       force_reset = 1'b0;
    logic       tx_ready = 1'b0;
    logic       rx_ready = 1'b0;
    logic       rx_block_lock = 1'b0;
    logic       xcvr_reset, mac_reset_n, link_up, fault;
    logic [3:0] retry_count;
    logic [2:0] link_state;

    int errors = 0;
    int checks = 0;

    xcvr_link_recovery #(
        .RESET_PULSE_CYCLES   (PULSE),
        .READY_TIMEOUT_CYCLES (RT),
        .LOCK_TIMEOUT_CYCLES  (LT),
        .LOCK_STABLE_CYCLES   (STB),
        .LOSS_FILTER_CYCLES   (LOSS),
        .MAX_RETRIES          (MAXR),
        .CNT_W                (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .force_reset   (force_reset),
        .tx_ready      (tx_ready),
        .rx_ready      (rx_ready),
        .rx_block_lock (rx_block_lock),
        .xcvr_reset    (xcvr_reset),
        .mac_reset_n   (mac_reset_n),
        .link_up       (link_up),
        .fault         (fault),
        .retry_count   (retry_count),
        .link_state    (link_state)
    );

    always #5 clock = ~clock;

    // Model: phase (0..4), cycles spent in phase, current lock run lengths,
    // failed attempts, cycles since reset release, and the pin's two-cycle delay line.
    typedef struct {
        int st;
        int age;
        int run1;
        int run0;
        int tries;
        int held;
        bit p1;
        bit p2;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st = 0; r.age = 0; r.run1 = 0; r.run0 = 0;
        r.tries = 0; r.held = 0; r.p1 = 0; r.p2 = 0;
        return r;
    endfunction

    function automatic mdl_t enter(mdl_t x, int s);
        x.st = s; x.age = 0; x.run1 = 0; x.run0 = 0;
        return x;
    endfunction

    function automatic mdl_t mdl_next(mdl_t c, bit pin, bit frc, bit rdy);
        mdl_t n;
        bit   ls;
        bit   bad;
        n   = c;
        ls  = c.p2;
        bad = 0;
        n.p1 = pin;
        n.p2 = c.p1;
        if (c.held < SYNC) begin
            n.held = c.held + 1;
            return n;
        end
        n.age = c.age + 1;
        if (frc) begin
            n = enter(n, 0);
            n.tries = 0;
            return n;
        end
        case (c.st)
            0: if (c.age == PULSE - 1) n = enter(n, 1);
            1: begin
                if (rdy) n = enter(n, 2);
                else if (c.age == RT - 1) bad = 1;
            end
            2: begin
                if (!rdy) bad = 1;
                else if (c.run1 >= STB) begin n = enter(n, 3); n.tries = 0; end
                else if (c.age == LT - 1) bad = 1;
                else n.run1 = ls ? c.run1 + 1 : 0;
            end
            3: begin
                if (!rdy || c.run0 >= LOSS) bad = 1;
                else n.run0 = ls ? 0 : c.run0 + 1;
            end
            default: ;
        endcase
        if (bad) begin
            n.tries = (c.tries < 15) ? c.tries + 1 : 15;
            n = enter(n, (MAXR != 0 && n.tries >= MAXR) ? 4 : 0);
        end
        return n;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) m <= mdl_reset();
        else          m <= mdl_next(m, rx_block_lock, force_reset, tx_ready && rx_ready);
    end

    task automatic apply_reset();
        reset_n = 1'b0;
        force_reset = 1'b0;
        tx_ready = 1'b0;
        rx_ready = 1'b0;
        rx_block_lock = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clock);
        checks++; if (xcvr_reset !== 1'b1) begin errors++; $display("FAIL reset_xcvr_reset: got %b want 1", xcvr_reset); end
        checks++; if (mac_reset_n !== 1'b0) begin errors++; $display("FAIL reset_mac_reset_n: got %b want 0", mac_reset_n); end
        checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up: got %b want 0", link_up); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
        checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
        checks++; if (link_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", link_state); end
    endtask

    task automatic test_bringup();
        int first_low = -1;
        int lu_cyc = -1;
        apply_reset();
        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            if (!xcvr_reset && first_low < 0) first_low = c;
            if (link_up && lu_cyc < 0) lu_cyc = c;
            if (c == 10) begin
                tx_ready = 1'b1; rx_ready = 1'b1; rx_block_lock = 1'b1;
            end
        end
        checks++; if (first_low != SYNC + PULSE) begin errors++; $display("FAIL bringup_pulse_end: got cycle %0d want %0d", first_low, SYNC + PULSE); end
        checks++; if (lu_cyc != 10 + SYNC + STB + 1) begin errors++; $display("FAIL bringup_link_up_delay: got cycle %0d want %0d", lu_cyc, 10 + SYNC + STB + 1); end
        checks++; if (mac_reset_n !== 1'b1) begin errors++; $display("FAIL bringup_mac_reset_n: got %b want 1", mac_reset_n); end
        checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL bringup_retry: got %0d want 0", retry_count); end
        checks++; if (link_state !== 3'd3) begin errors++; $display("FAIL bringup_state: got %0d want 3", link_state); end
    endtask

    task automatic test_exhaust();
        int   rises[$];
        int   fault_cyc = -1;
        int   bad = 0;
        logic prev_xr = 1'b1;
        apply_reset();
        for (int c = 1; c <= 200 && fault_cyc < 0; c++) begin
            @(negedge clock);
            if (xcvr_reset && !prev_xr) rises.push_back(c);
            prev_xr = xcvr_reset;
            if (fault) fault_cyc = c;
        end
        checks++; if (fault_cyc < 0) begin errors++; $display("FAIL exhaust_fault_timeout: fault never rose within 200 cycles"); end
        checks++;
        if (rises.size() != 3) begin
            errors++; $display("FAIL exhaust_pulse_count: got %0d want 3", rises.size());
        end else begin
            checks++; if (rises[0] != SYNC + PULSE + RT) begin errors++; $display("FAIL exhaust_first_retry: got cycle %0d want %0d", rises[0], SYNC + PULSE + RT); end
            checks++; if (rises[1] - rises[0] != PULSE + RT) begin errors++; $display("FAIL exhaust_spacing1: got %0d want %0d", rises[1] - rises[0], PULSE + RT); end
            checks++; if (rises[2] - rises[1] != PULSE + RT) begin errors++; $display("FAIL exhaust_spacing2: got %0d want %0d", rises[2] - rises[1], PULSE + RT); end
            checks++; if (fault_cyc != rises[2]) begin errors++; $display("FAIL exhaust_fault_cycle: got %0d want %0d", fault_cyc, rises[2]); end
        end
        repeat (20) begin
            @(negedge clock);
            if (!xcvr_reset || !fault || link_up) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL exhaust_fault_hold: got %0d bad cycles want 0", bad); end
        checks++; if (retry_count !== 4'd3) begin errors++; $display("FAIL exhaust_retry: got %0d want 3", retry_count); end
        checks++; if (link_state !== 3'd4) begin errors++; $display("FAIL exhaust_state: got %0d want 4", link_state); end
    endtask

    task automatic test_force_fault();
        int hi = 1;
        int n = 0;
        force_reset = 1'b1;
        @(negedge clock);
        force_reset = 1'b0;
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL force_fault_clear: got %b want 0", fault); end
        checks++; if (retry_count !== 4'd0) begin errors++; $display("FAIL force_retry_clear: got %0d want 0", retry_count); end
        checks++; if (link_state !== 3'd0 || xcvr_reset !== 1'b1) begin errors++; $display("FAIL force_restart: got state %0d xcvr_reset %b want 0 and 1", link_state, xcvr_reset); end
        while (xcvr_reset && n < 20) begin
            @(negedge clock);
            n++;
            if (xcvr_reset) hi++;
        end
        checks++; if (hi != PULSE) begin errors++; $display("FAIL force_pulse_width: got %0d want %0d", hi, PULSE); end
        tx_ready = 1'b1; rx_ready = 1'b1; rx_block_lock = 1'b1;
        n = 0;
        while (!link_up && n < 60) begin @(negedge clock); n++; end
        checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL force_bringup: link_up got %b want 1 within 60 cycles", link_up); end
    endtask

    task automatic test_glitch();
        int   bad = 0;
        int   drop = -1;
        logic xr_at = 1'b0;
        int   rc_at = -1;
        rx_block_lock = 1'b0;
        repeat (3) @(negedge clock);
        rx_block_lock = 1'b1;
        repeat (15) begin
            @(negedge clock);
            if (!link_up || !mac_reset_n) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL glitch_short_kept_link: got %0d down cycles want 0", bad); end
        rx_block_lock = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (c == LOSS) rx_block_lock = 1'b1;
            if (!link_up && drop < 0) begin
                drop = c; xr_at = xcvr_reset; rc_at = retry_count;
            end
        end
        checks++; if (drop != SYNC + LOSS + 1) begin errors++; $display("FAIL glitch_loss_drop: got cycle %0d want %0d", drop, SYNC + LOSS + 1); end
        checks++; if (xr_at !== 1'b1) begin errors++; $display("FAIL glitch_loss_xcvr_reset: got %b want 1", xr_at); end
        checks++; if (rc_at != 1) begin errors++; $display("FAIL glitch_loss_retry: got %0d want 1", rc_at); end
    endtask

    task automatic test_ready_drop();
        int n = 0;
        int prev;
        rx_block_lock = 1'b0;
        while (link_state !== 3'd2 && n < 40) begin @(negedge clock); n++; end
        checks++; if (link_state !== 3'd2) begin errors++; $display("FAIL ready_drop_reach_wait_lock: got state %0d want 2", link_state); end
        prev = int'(retry_count);
        rx_ready = 1'b0;
        @(negedge clock);
        rx_ready = 1'b1;
        checks++; if (link_state !== 3'd0) begin errors++; $display("FAIL ready_drop_state: got %0d want 0", link_state); end
        checks++; if (int'(retry_count) != prev + 1) begin errors++; $display("FAIL ready_drop_retry: got %0d want %0d", retry_count, prev + 1); end
        checks++; if (xcvr_reset !== 1'b1) begin errors++; $display("FAIL ready_drop_xcvr_reset: got %b want 1", xcvr_reset); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (link_state !== 3'd2 && n < 40) begin @(negedge clock); n++; end
        checks++; if (link_state !== 3'd2 || retry_count === 4'd0) begin errors++; $display("FAIL async_setup: got state %0d retry %0d want 2 and nonzero", link_state, retry_count); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (xcvr_reset !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL async_xcvr_fault: got %b %b want 1 0", xcvr_reset, fault); end
        checks++; if (link_up !== 1'b0 || mac_reset_n !== 1'b0) begin errors++; $display("FAIL async_link: got %b %b want 0 0", link_up, mac_reset_n); end
        checks++; if (retry_count !== 4'd0 || link_state !== 3'd0) begin errors++; $display("FAIL async_state: got retry %0d state %0d want 0 0", retry_count, link_state); end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int         mode = 0;
        logic [10:0] got, want;
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            if (c % 400 == 0) mode = int'($urandom_range(0, 3));
            want = {(m.st == 0 || m.st == 4), (m.st == 3), (m.st == 3), (m.st == 4), 4'(m.tries), 3'(m.st)};
            got  = {xcvr_reset, mac_reset_n, link_up, fault, retry_count, link_state};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random_cycle_%0d: got xr/mac/lu/flt/retry/state=%b want %b", c, got, want);
            end
            case (mode)
                0: begin
                    tx_ready = ($urandom_range(0, 499) != 0);
                    rx_ready = ($urandom_range(0, 499) != 0);
                    if (rx_block_lock) rx_block_lock = ($urandom_range(0, 39) != 0);
                    else               rx_block_lock = ($urandom_range(0, 2) == 0);
                end
                1: begin
                    tx_ready = $urandom_range(0, 1) == 1;
                    rx_ready = $urandom_range(0, 3) != 0;
                    rx_block_lock = $urandom_range(0, 1) == 1;
                end
                2: begin
                    tx_ready = 1'b0;
                    rx_ready = $urandom_range(0, 1) == 1;
                    rx_block_lock = $urandom_range(0, 1) == 1;
                end
                default: begin
                    tx_ready = 1'b1;
                    rx_ready = 1'b1;
                    if (rx_block_lock) rx_block_lock = ($urandom_range(0, 15) != 0);
                    else               rx_block_lock = ($urandom_range(0, 3) == 0);
                end
            endcase
            force_reset = ($urandom_range(0, 299) == 0);
        end
        force_reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        test_reset();
        test_bringup();
        test_exhaust();
        test_force_fault();
        test_glitch();
        test_ready_drop();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
